// File: rtl/addsub_pipe.sv
// Pipelined ripple add/subtract: one WIDTH/STAGES-bit slice per stage, global stall on output backpressure.
// Define ADDSUB_SATURATE_EN to clamp Sum on signed overflow; default build wraps modulo 2^WIDTH.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  output logic             V,
  output logic             Z
);

  localparam int unsigned SW  = WIDTH / STAGES;
  localparam int unsigned LST = STAGES - 1;
  localparam int unsigned MSB = WIDTH - 1;

  logic adv;

  // What enters each stage, and what that stage produces.
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];
  logic [WIDTH-1:0] s_out [STAGES];
  logic             c_out [STAGES];

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0] slice_sum;

    if (k == 0) begin : g_in
      // Subtract folds into an add of ~B with inverted borrow as carry-in.
      assign a_in[k] = A;
      assign b_in[k] = op ? ~B : B;
      assign s_in[k] = '0;
      assign c_in[k] = Cin ^ op;
      assign v_in[k] = in_valid;
    end else begin : g_reg
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_in[k-1];
          b_q <= b_in[k-1];
          s_q <= s_out[k-1];
          c_q <= c_out[k-1];
          v_q <= v_in[k-1];
        end
      end

      assign a_in[k] = a_q;
      assign b_in[k] = b_q;
      assign s_in[k] = s_q;
      assign c_in[k] = c_q;
      assign v_in[k] = v_q;
    end

    assign slice_sum = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                     + (SW+1)'(c_in[k]);
    assign c_out[k]  = slice_sum[SW];
    // Slice k of s_in is still zero, so OR-ing the new slice in is an insert.
    assign s_out[k]  = s_in[k] | (WIDTH'(slice_sum[SW-1:0]) << (k*SW));
  end

  logic             msb_carry;
  logic             ovf;
  logic [WIDTH-1:0] sum_fin;

  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign msb_carry = s_out[LST][MSB] ^ a_in[LST][MSB] ^ b_in[LST][MSB];
  assign ovf       = msb_carry ^ c_out[LST];

`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  assign sum_fin = ovf ? (a_in[LST][MSB] ? SAT_NEG : SAT_POS) : s_out[LST];
`else
  assign sum_fin = s_out[LST];
`endif

  // Output register; result fields only move when a valid beat lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Co        <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
    end else if (adv) begin
      out_valid <= v_in[LST];
      if (v_in[LST]) begin
        Sum <= sum_fin;
        Co  <= c_out[LST];
        V   <= ovf;
        Z   <= (sum_fin == '0);
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: expected results queued at acceptance, compared at output handshake.
module tb_addsub_pipe;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             v;
    logic             z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Co;
  logic             V;
  logic             Z;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Co(Co), .V(V), .Z(Z)
  );

  // Reference built from integer arithmetic, independent of slice/carry structure.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic o);
    logic [WIDTH:0] full;
    int             sa, sb, sr;
    exp_t           e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!o) begin
      full = {1'b0, a} + {1'b0, b} + 17'(cin);
      sr   = sa + sb + int'(cin);
    end else begin
      full = {1'b0, a} + {1'b0, ~b} + 17'(!cin);
      sr   = sa - sb - int'(cin);
    end
    e.sum = full[WIDTH-1:0];
    e.co  = full[WIDTH];
    e.v   = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SATURATE_EN
    if (sr > 32767)       e.sum = 16'h7FFF;
    else if (sr < -32768) e.sum = 16'h8000;
`endif
    e.z = (e.sum == '0);
    return e;
  endfunction

  // Output side of the scoreboard: one pop per handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got Sum=%h with no beat outstanding", Sum);
      end else begin
        e = sbq.pop_front();
        if (Sum !== e.sum) begin
          errors++;
          $display("FAIL result_sum: got %h expected %h", Sum, e.sum);
        end
        checks++;
        if (Co !== e.co) begin
          errors++;
          $display("FAIL result_co: got %b expected %b (Sum=%h)", Co, e.co, e.sum);
        end
        checks++;
        if (V !== e.v) begin
          errors++;
          $display("FAIL result_v: got %b expected %b (Sum=%h)", V, e.v, e.sum);
        end
        checks++;
        if (Z !== e.z) begin
          errors++;
          $display("FAIL result_z: got %b expected %b (Sum=%h)", Z, e.z, e.sum);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still outstanding, required 0", name, sbq.size());
      sbq.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; op = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if ({Sum, Co, V, Z} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got Sum=%h Co=%b V=%b Z=%b expected all 0", Sum, Co, V, Z);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  // Single beat into an empty pipe; counts edges from acceptance to out_valid.
  task automatic test_latency(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, input logic o);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1; A = a; B = b; Cin = cin; op = o;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    sbq.push_back(model(a, b, cin, o));
    @(posedge clk);
    n = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      #1;
    end
    checks++;
    if (n != STAGES) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, STAGES);
    end
    wait_drain(name);
  endtask

  task automatic test_directed();
    test_latency("pos_overflow", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    test_latency("carry_zero",   16'hFFFF, 16'h0001, 1'b0, 1'b0);
    test_latency("sub_negative", 16'h0005, 16'h0007, 1'b0, 1'b1);
    test_latency("sub_overflow", 16'h8000, 16'h0001, 1'b0, 1'b1);
    test_latency("sub_borrow",   16'h0010, 16'h0003, 1'b1, 1'b1);
    test_latency("add_cin",      16'h00FF, 16'h0F00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0]       pat = 4'b1001;
    int               beat = 0;
    int               cyc = 0;
    logic             held = 1'b0;
    logic [WIDTH+2:0] held_val = '0;
    while ((beat < 8 || sbq.size() != 0) && cyc < 200) begin
      out_ready = pat[cyc % 4];
      if (beat < 8) begin
        in_valid = 1'b1; A = 16'(beat); B = 16'(beat); Cin = 1'b1; op = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL b2b_in_ready: got %b expected %b (cycle %0d)", in_ready,
                 !(out_valid && !out_ready), cyc);
      end
      if (held) begin
        checks++;
        if (!out_valid || {Sum, Co, V, Z} !== held_val) begin
          errors++;
          $display("FAIL b2b_hold: got valid=%b val=%h expected valid=1 val=%h", out_valid,
                   {Sum, Co, V, Z}, held_val);
        end
      end
      held     = out_valid && !out_ready;
      held_val = {Sum, Co, V, Z};
      if (in_valid && in_ready) begin
        sbq.push_back(model(16'(beat), 16'(beat), 1'b1, 1'b0));
        beat++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (beat != 8) begin errors++; $display("FAIL b2b_accepted: got %0d beats expected 8", beat); end
    wait_drain("b2b");
  endtask

  task automatic test_random();
    int beat = 0;
    int cyc = 0;
    logic [WIDTH-1:0] edge_v [4];
    edge_v[0] = 16'h0000; edge_v[1] = 16'hFFFF; edge_v[2] = 16'h7FFF; edge_v[3] = 16'h8000;
    while (beat < 60 && cyc < 2000) begin
      out_ready = ($urandom_range(3) != 0);
      in_valid  = ($urandom_range(4) != 0);
      A   = ($urandom_range(3) == 0) ? edge_v[$urandom_range(3)] : 16'($urandom);
      B   = ($urandom_range(3) == 0) ? edge_v[$urandom_range(3)] : 16'($urandom);
      Cin = 1'($urandom);
      op  = 1'($urandom);
      #1;
      if (in_valid && in_ready) begin
        sbq.push_back(model(A, B, Cin, op));
        beat++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain("random");
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 16'(16'h0100 + i); B = 16'(i); Cin = 1'b0; op = 1'b0;
      #1;
      if (in_ready) sbq.push_back(model(A, B, Cin, op));
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight_pre_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    sbq.delete();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_out_valid: got %b expected 0", out_valid); end
    checks++;
    if ({Sum, Co, V, Z} !== '0) begin
      errors++;
      $display("FAIL midflight_outputs: got Sum=%h Co=%b V=%b Z=%b expected all 0", Sum, Co, V, Z);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midflight_in_ready: got %b expected 1", in_ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midflight_flushed: got %0d valid cycles expected 0", seen); end
    test_latency("after_reset", 16'h0001, 16'h0002, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
